// File: rtl/tdp_ram_sc_pkg.sv
// Shared types and the byte-merge helper for the true dual-port RAM with clear sweep.
package tdp_ram_sc_pkg;

  typedef enum logic [1:0] {
    RD_FIRST,
    WR_FIRST,
    NO_CHANGE
  } wr_mode_e;

  typedef enum logic {
    CLEAR,
    READY
  } clr_state_e;

  // Widest word the merge helper supports; callers zero-extend and truncate.
  localparam int unsigned MAX_DW = 256;
  localparam int unsigned MAX_BE = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < MAX_BE; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tdp_ram_sc_clr.sv
// Clear sweep: zeroes every word once after reset, one address per cycle.
module tdp_ram_sc_clr
  import tdp_ram_sc_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = 256,
  localparam int unsigned AW = $clog2(DATA_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_busy,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (ptr_q == AW'(DATA_DEPTH - 1)) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        READY:   state_q <= READY;
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign init_busy = busy_q;
  assign clr_addr  = ptr_q;

endmodule

// File: rtl/tdp_ram_sc.sv
// True dual-port single-clock RAM with byte enables, per-port write modes and a post-reset
// clear sweep. Define TDP_RAM_SC_OREG_EN to add one output register stage per port.
module tdp_ram_sc
  import tdp_ram_sc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DATA_DEPTH = 256,
  parameter wr_mode_e    WR_MODE_A  = WR_FIRST,
  parameter wr_mode_e    WR_MODE_B  = RD_FIRST,
  localparam int unsigned AW = $clog2(DATA_DEPTH),
  localparam int unsigned BW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  ena,
  input  logic [BW-1:0]         wea,
  input  logic [AW-1:0]         addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  vala,
  input  logic                  enb,
  input  logic [BW-1:0]         web,
  input  logic [AW-1:0]         addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  valb,
  output logic                  coll
);

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BW-1:0]         be
  );
    return DATA_WIDTH'(byte_merge(MAX_DW'(old_w), MAX_DW'(new_w), MAX_BE'(be)));
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [AW-1:0]         clr_addr;

  logic                  act, a_req, b_req, a_wr, b_wr, a_in, b_in, coll_c;
  logic [DATA_WIDTH-1:0] old_a, old_b, mrg_a, mrg_b;
  logic                  ra_v, rb_v;
  logic [DATA_WIDTH-1:0] ra_d, rb_d;

  logic [DATA_WIDTH-1:0] douta_q, doutb_q;
  logic                  vala_q, valb_q, coll_q;

  tdp_ram_sc_clr #(.DATA_DEPTH(DATA_DEPTH)) u_clr (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_addr  (clr_addr)
  );

  // Port decode; on a same-address double write port A's bytes land on top of port B's.
  always_comb begin
    act    = !rst && !init_busy;
    a_req  = act && ena;
    b_req  = act && enb;
    a_wr   = a_req && (|wea);
    b_wr   = b_req && (|web);
    a_in   = 32'(addra) < DATA_DEPTH;
    b_in   = 32'(addrb) < DATA_DEPTH;
    old_a  = a_in ? mem_q[addra] : '0;
    old_b  = b_in ? mem_q[addrb] : '0;
    coll_c = a_wr && b_wr && a_in && b_in && (addra == addrb);
    mrg_b  = merge(old_b, dinb, web);
    mrg_a  = merge(coll_c ? mrg_b : old_a, dina, wea);
  end

  always_comb begin
    ra_v = 1'b0;
    ra_d = old_a;
    if (a_req) begin
      if (!a_wr || WR_MODE_A == RD_FIRST) begin
        ra_v = 1'b1;
      end else if (WR_MODE_A == WR_FIRST) begin
        ra_v = 1'b1;
        ra_d = a_in ? mrg_a : '0;
      end
    end
  end

  always_comb begin
    rb_v = 1'b0;
    rb_d = old_b;
    if (b_req) begin
      if (!b_wr || WR_MODE_B == RD_FIRST) begin
        rb_v = 1'b1;
      end else if (WR_MODE_B == WR_FIRST) begin
        rb_v = 1'b1;
        rb_d = !b_in ? '0 : (coll_c ? mrg_a : mrg_b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init_busy && !rst) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (b_wr && b_in) mem_q[addrb] <= mrg_b;
      if (a_wr && a_in) mem_q[addra] <= mrg_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      douta_q <= '0;
      doutb_q <= '0;
      vala_q  <= 1'b0;
      valb_q  <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      vala_q <= ra_v;
      valb_q <= rb_v;
      coll_q <= coll_c;
      if (ra_v) douta_q <= ra_d;
      if (rb_v) doutb_q <= rb_d;
    end
  end

  assign coll = coll_q;

`ifdef TDP_RAM_SC_OREG_EN
  logic [DATA_WIDTH-1:0] douta2_q, doutb2_q;
  logic                  vala2_q, valb2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      douta2_q <= '0;
      doutb2_q <= '0;
      vala2_q  <= 1'b0;
      valb2_q  <= 1'b0;
    end else begin
      douta2_q <= douta_q;
      doutb2_q <= doutb_q;
      vala2_q  <= vala_q;
      valb2_q  <= valb_q;
    end
  end

  assign douta = douta2_q;
  assign vala  = vala2_q;
  assign doutb = doutb2_q;
  assign valb  = valb2_q;
`else
  assign douta = douta_q;
  assign vala  = vala_q;
  assign doutb = doutb_q;
  assign valb  = valb_q;
`endif

endmodule

// File: tb/tb_tdp_ram_sc.sv
// Self-checking bench for tdp_ram_sc: directed scenarios plus randomized traffic against a reference model.
module tb_tdp_ram_sc;

  localparam int DW = 16;
  localparam int DD = 256;
  localparam int AW = 8;
`ifdef TDP_RAM_SC_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init_busy;
  logic          ena = 1'b0, enb = 1'b0;
  logic [1:0]    wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dina = '0, dinb = '0;
  logic [DW-1:0] douta, doutb;
  logic          vala, valb, coll;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image plus a LAT-deep view of each port's output.
  logic [DW-1:0] ref_mem [DD];
  logic [DW-1:0] pa_d [2];
  logic [DW-1:0] pb_d [2];
  logic          pa_v [2];
  logic          pb_v [2];
  logic          e_coll;

  always #5 clk = ~clk;

  tdp_ram_sc #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta),
    .vala      (vala),
    .enb       (enb),
    .web       (web),
    .addrb     (addrb),
    .dinb      (dinb),
    .doutb     (doutb),
    .valb      (valb),
    .coll      (coll)
  );

  task automatic model_cleared();
    for (int i = 0; i < DD; i++) ref_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      pa_d[i] = '0; pb_d[i] = '0; pa_v[i] = 1'b0; pb_v[i] = 1'b0;
    end
    e_coll = 1'b0;
  endtask

  // One READY-state cycle: drive at negedge, advance model at posedge, return at next negedge.
  task automatic op(input logic ea, input logic [1:0] wa, input logic [7:0] aa, input logic [15:0] da,
                    input logic eb, input logic [1:0] wb, input logic [7:0] ab, input logic [15:0] db);
    logic [DW-1:0] oa, ob;
    logic          wra, wrb;
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    @(posedge clk);
    oa  = ref_mem[aa];
    ob  = ref_mem[ab];
    wra = ea && (wa != 2'b00);
    wrb = eb && (wb != 2'b00);
    e_coll = wra && wrb && (aa == ab);
    if (wrb) for (int i = 0; i < 2; i++) if (wb[i]) ref_mem[ab][i*8 +: 8] = db[i*8 +: 8];
    if (wra) for (int i = 0; i < 2; i++) if (wa[i]) ref_mem[aa][i*8 +: 8] = da[i*8 +: 8];
    pa_d[1] = pa_d[0]; pa_v[1] = pa_v[0];
    pb_d[1] = pb_d[0]; pb_v[1] = pb_v[0];
    pa_v[0] = ea;
    if (ea) pa_d[0] = wra ? ref_mem[aa] : oa;
    pb_v[0] = eb;
    if (eb) pb_d[0] = ob;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 2'b00, 8'd0, 16'd0, 1'b0, 2'b00, 8'd0, 16'd0);
  endtask

  task automatic test_reset();
    int n;
    ena = 1'b1; wea = 2'b11; addra = 8'd0; dina = 16'hDEAD;
    enb = 1'b1; web = 2'b00; addrb = 8'd1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (init_busy !== 1'b1 || vala !== 1'b0 || valb !== 1'b0 || coll !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b vala=%b valb=%b coll=%b, want 1 0 0 0", init_busy, vala, valb, coll);
    end
    checks++;
    if (douta !== 16'h0000 || doutb !== 16'h0000) begin
      errors++;
      $display("FAIL reset_dout: douta=%h doutb=%h, want 0000 0000", douta, doutb);
    end
    n = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      n++;
      checks++;
      if (vala !== 1'b0 || valb !== 1'b0) begin
        errors++;
        $display("FAIL clear_ignores_ports: vala=%b valb=%b at clear cycle %0d, want 0 0", vala, valb, n);
      end
      @(negedge clk);
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL clear_length: init_busy high %0d cycles, want 256", n);
    end
    model_cleared();
    op(1'b1, 2'b00, 8'd255, 16'd0, 1'b1, 2'b00, 8'd0, 16'd0);
    idle(LAT - 1);
    checks++;
    if (vala !== 1'b1 || douta !== 16'h0000) begin
      errors++;
      $display("FAIL read_255_after_clear: vala=%b douta=%h, want 1 0000", vala, douta);
    end
    checks++;
    if (valb !== 1'b1 || doutb !== 16'h0000) begin
      errors++;
      $display("FAIL write_during_clear_dropped: valb=%b doutb=%h, want 1 0000", valb, doutb);
    end
    idle(1);
    checks++;
    if (vala !== 1'b0 || valb !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid_low: vala=%b valb=%b, want 0 0", vala, valb);
    end
  endtask

  task automatic test_write_read();
    op(1'b1, 2'b11, 8'd5, 16'hBEEF, 1'b0, 2'b00, 8'd0, 16'd0);
    idle(LAT - 1);
    checks++;
    if (vala !== 1'b1 || douta !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_first_return: vala=%b douta=%h, want 1 beef", vala, douta);
    end
    op(1'b0, 2'b00, 8'd0, 16'd0, 1'b1, 2'b00, 8'd5, 16'd0);
    idle(LAT - 1);
    checks++;
    if (valb !== 1'b1 || doutb !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_b_addr5: valb=%b doutb=%h, want 1 beef", valb, doutb);
    end
    idle(1);
    checks++;
    if (valb !== 1'b0 || doutb !== 16'hBEEF) begin
      errors++;
      $display("FAIL doutb_hold: valb=%b doutb=%h, want 0 beef", valb, doutb);
    end
  endtask

  task automatic test_collision();
    op(1'b1, 2'b01, 8'd7, 16'h1122, 1'b1, 2'b11, 8'd7, 16'h3344);
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL coll_set: coll=%b, want 1", coll);
    end
    idle(1);
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL coll_one_cycle: coll=%b, want 0", coll);
    end
    op(1'b1, 2'b00, 8'd7, 16'd0, 1'b0, 2'b00, 8'd0, 16'd0);
    idle(LAT - 1);
    checks++;
    if (vala !== 1'b1 || douta !== 16'h3322) begin
      errors++;
      $display("FAIL coll_merge: vala=%b douta=%h, want 1 3322", vala, douta);
    end
  endtask

  task automatic test_read_during_write();
    op(1'b1, 2'b11, 8'd9, 16'h00AA, 1'b0, 2'b00, 8'd0, 16'd0);
    op(1'b1, 2'b11, 8'd9, 16'h5555, 1'b1, 2'b00, 8'd9, 16'd0);
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL rdw_no_coll: coll=%b, want 0", coll);
    end
    idle(LAT - 1);
    checks++;
    if (doutb !== 16'h00AA || douta !== 16'h5555) begin
      errors++;
      $display("FAIL rdw_values: doutb=%h douta=%h, want 00aa 5555", doutb, douta);
    end
  endtask

  task automatic test_random();
    logic          ea, eb;
    logic [1:0]    wa, wb;
    logic [7:0]    aa, ab;
    logic [15:0]   da, db;
    for (int k = 0; k < 400; k++) begin
      ea = ($urandom_range(0, 3) != 0);
      eb = ($urandom_range(0, 3) != 0);
      wa = 2'($urandom_range(0, 3));
      wb = 2'($urandom_range(0, 3));
      aa = 8'($urandom_range(0, 15));
      ab = 8'($urandom_range(0, 15));
      da = 16'($urandom);
      db = 16'($urandom);
      op(ea, wa, aa, da, eb, wb, ab, db);
      checks++;
      if (vala !== pa_v[LAT-1] || (pa_v[LAT-1] && douta !== pa_d[LAT-1])) begin
        errors++;
        $display("FAIL rand_a[%0d]: vala=%b douta=%h, want %b %h", k, vala, douta, pa_v[LAT-1], pa_d[LAT-1]);
      end
      checks++;
      if (valb !== pb_v[LAT-1] || (pb_v[LAT-1] && doutb !== pb_d[LAT-1])) begin
        errors++;
        $display("FAIL rand_b[%0d]: valb=%b doutb=%h, want %b %h", k, valb, doutb, pb_v[LAT-1], pb_d[LAT-1]);
      end
      checks++;
      if (coll !== e_coll) begin
        errors++;
        $display("FAIL rand_coll[%0d]: coll=%b, want %b", k, coll, e_coll);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    op(1'b1, 2'b11, 8'd3, 16'h1234, 1'b0, 2'b00, 8'd0, 16'd0);
    idle(LAT);
    ena = 1'b0; enb = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clk);
    checks++;
    if (init_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_clear: init_busy=%b, want 1", init_busy);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL restart_clear_length: init_busy high %0d cycles, want 256", n);
    end
    model_cleared();
    op(1'b1, 2'b00, 8'd3, 16'd0, 1'b0, 2'b00, 8'd0, 16'd0);
    idle(LAT - 1);
    checks++;
    if (vala !== 1'b1 || douta !== 16'h0000) begin
      errors++;
      $display("FAIL addr3_recleared: vala=%b douta=%h, want 1 0000", vala, douta);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_collision();
    test_read_during_write();
    test_random();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
